// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-side memory ports and the main-memory port that
// meet at the arbiter. The slave modport is the arbiter's view; the master
// modport is the view of everything around it (both caches and the memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    // Data cache port
    logic              d_READ;
    logic              d_WRITE;
    logic [ADDR_W-1:0] d_ADDRESS;
    logic [DATA_W-1:0] d_WRITEDATA;
    logic [DATA_W-1:0] d_READDATA;
    logic              d_BUSYWAIT;

    // Instruction cache port (read-only)
    logic              i_READ;
    logic [ADDR_W-1:0] i_ADDRESS;
    logic [DATA_W-1:0] i_READDATA;
    logic              i_BUSYWAIT;

    // Main memory port
    logic              mem_READ;
    logic              mem_WRITE;
    logic [ADDR_W-1:0] mem_ADDRESS;
    logic [DATA_W-1:0] mem_WRITEDATA;
    logic [DATA_W-1:0] mem_READDATA;
    logic              mem_BUSYWAIT;
    logic              mem_TIMEOUT;

    modport slave (
        input  d_READ, d_WRITE, d_ADDRESS, d_WRITEDATA,
        output d_READDATA, d_BUSYWAIT,
        input  i_READ, i_ADDRESS,
        output i_READDATA, i_BUSYWAIT,
        output mem_READ, mem_WRITE, mem_ADDRESS, mem_WRITEDATA, mem_TIMEOUT,
        input  mem_READDATA, mem_BUSYWAIT
    );

    modport master (
        output d_READ, d_WRITE, d_ADDRESS, d_WRITEDATA,
        input  d_READDATA, d_BUSYWAIT,
        output i_READ, i_ADDRESS,
        input  i_READDATA, i_BUSYWAIT,
        input  mem_READ, mem_WRITE, mem_ADDRESS, mem_WRITEDATA, mem_TIMEOUT,
        output mem_READDATA, mem_BUSYWAIT
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide main memory between the
// instruction cache (reads only) and the data cache (reads and write-backs).
// One block transfer at a time; a watchdog flags a memory that never
// drops its busywait.
module mem_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic         CLK,
    input logic         RESET,
    mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_D,
        GRANT_I,
        DONE_D,
        DONE_I
    } state_e;

    typedef enum logic {
        OWNER_D,
        OWNER_I
    } owner_e;

    state_e            state_q;
    owner_e            last_grant_q;
    logic              first_q;      // high during the first cycle of a grant
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              timeout_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] i_rdata_q;

    logic d_req;
    logic i_req;
    logic pick_d;

    // Request decode and round-robin choice for the next grant out of IDLE.
    // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
    always_comb begin
        d_req  = bus.d_READ | bus.d_WRITE;
        i_req  = bus.i_READ;
        // D wins when alone, or on a tie when I was served last.
        pick_d = d_req & (~i_req | (last_grant_q == OWNER_I));
    end

    // Arbitration FSM with registered memory strobes, returned data and watchdog.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_I;
            first_q      <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            d_rdata_q    <= '0;
            i_rdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (d_req | i_req) begin
                        first_q  <= 1'b1;
                        wd_cnt_q <= '0;
                        if (pick_d) begin
                            state_q     <= GRANT_D;
                            mem_addr_q  <= bus.d_ADDRESS;
                            // Read and write together is a write-back.
                            mem_read_q  <= bus.d_READ & ~bus.d_WRITE;
                            mem_write_q <= bus.d_WRITE;
                            mem_wdata_q <= bus.d_WRITE ? bus.d_WRITEDATA : '0;
                        end else begin
                            state_q     <= GRANT_I;
                            mem_addr_q  <= bus.i_ADDRESS;
                            mem_read_q  <= 1'b1;
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= '0;
                        end
                    end
                end

                GRANT_D, GRANT_I: begin
                    first_q <= 1'b0;
                    if (bus.mem_BUSYWAIT) begin
                        // Watchdog: saturating count of busy grant cycles;
                        // the flag sets on the edge the count reaches TIMEOUT.
                        if (wd_cnt_q != CNT_W'(TIMEOUT)) begin
                            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                        end
                        if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end else if (!first_q) begin
                        // Busywait on the first grant cycle is still settling
                        // from the previous access, so completion waits a cycle.
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state_q == GRANT_D) begin
                            state_q      <= DONE_D;
                            last_grant_q <= OWNER_D;
                            if (mem_read_q) begin
                                d_rdata_q <= bus.mem_READDATA;
                            end
                        end else begin
                            state_q      <= DONE_I;
                            last_grant_q <= OWNER_I;
                            i_rdata_q    <= bus.mem_READDATA;
                        end
                    end
                end

                DONE_D, DONE_I: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A requester is stalled whenever it asks, except in its own DONE cycle.
    assign bus.d_BUSYWAIT    = d_req & (state_q != DONE_D);
    assign bus.i_BUSYWAIT    = i_req & (state_q != DONE_I);

    assign bus.d_READDATA    = d_rdata_q;
    assign bus.i_READDATA    = i_rdata_q;
    assign bus.mem_READ      = mem_read_q;
    assign bus.mem_WRITE     = mem_write_q;
    assign bus.mem_ADDRESS   = mem_addr_q;
    assign bus.mem_WRITEDATA = mem_wdata_q;
    assign bus.mem_TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic from both caches, checked against a transaction-level memory image.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 255;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Physical memory behind the arbiter, and the expected memory image
    // updated in transaction completion order.
    logic [DW-1:0] phys    [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] d_last_rd;
    int            grant_log [$];   // 0 = D served, 1 = I served

    // Memory model: busy for a chosen number of cycles per access, then
    // performs the access; also watches that the bus stays frozen.
    int            fixed_lat = -1;
    bit            stuck     = 1'b0;
    bit            act       = 1'b0;
    bit            applied   = 1'b0;
    int            remain    = 0;
    int            bus_violations = 0;
    logic          snap_rd, snap_wr;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;

    always @(negedge CLK) begin
        if (bus.mem_READ || bus.mem_WRITE) begin
            if (!act) begin
                act        = 1'b1;
                applied    = 1'b0;
                remain     = stuck ? (1 << 30) : (fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 4)));
                snap_rd    = bus.mem_READ;
                snap_wr    = bus.mem_WRITE;
                snap_addr  = bus.mem_ADDRESS;
                snap_wdata = bus.mem_WRITEDATA;
                if (bus.mem_READ && bus.mem_WRITE) bus_violations++;
                if (bus.mem_READ && bus.mem_WRITEDATA != '0) bus_violations++;
            end else if ({bus.mem_READ, bus.mem_WRITE, bus.mem_ADDRESS, bus.mem_WRITEDATA}
                         != {snap_rd, snap_wr, snap_addr, snap_wdata}) begin
                bus_violations++;
            end
            if (remain > 0) begin
                remain--;
                bus.mem_BUSYWAIT = 1'b1;
                bus.mem_READDATA = $urandom;
            end else begin
                bus.mem_BUSYWAIT = 1'b0;
                if (!applied) begin
                    applied = 1'b1;
                    if (snap_wr) phys[snap_addr] = snap_wdata;
                    else         bus.mem_READDATA = phys[snap_addr];
                end
            end
        end else begin
            act              = 1'b0;
            bus.mem_BUSYWAIT = 1'($urandom_range(0, 1));
            bus.mem_READDATA = $urandom;
        end
    end

    // Data cache agent: one transaction, starting at a negedge, returning at
    // the negedge of its DONE cycle with the request dropped.
    task automatic d_access(input bit wr, input bit both, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, output int cyc);
        bus.d_READ      = !wr || both;
        bus.d_WRITE     = wr;
        bus.d_ADDRESS   = addr;
        bus.d_WRITEDATA = wd;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (bus.d_BUSYWAIT && cyc < 2000);
        check("d_done", bus.d_BUSYWAIT, 1'b0);
        grant_log.push_back(0);
        if (wr) begin
            ref_mem[addr] = wd;
            check("d_rdata_hold", bus.d_READDATA, d_last_rd);
        end else begin
            check("d_rdata", bus.d_READDATA, ref_mem[addr]);
            d_last_rd = ref_mem[addr];
        end
        bus.d_READ      = 1'b0;
        bus.d_WRITE     = 1'b0;
        bus.d_ADDRESS   = AW'($urandom);
        bus.d_WRITEDATA = $urandom;
    endtask

    // Instruction cache agent, same protocol, reads only.
    task automatic i_access(input logic [AW-1:0] addr, output int cyc);
        bus.i_READ    = 1'b1;
        bus.i_ADDRESS = addr;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (bus.i_BUSYWAIT && cyc < 2000);
        check("i_done", bus.i_BUSYWAIT, 1'b0);
        grant_log.push_back(1);
        check("i_rdata", bus.i_READDATA, ref_mem[addr]);
        bus.i_READ    = 1'b0;
        bus.i_ADDRESS = AW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc_d, cyc_i, cyc_a, cyc_b;

        bus.d_READ = 0; bus.d_WRITE = 0; bus.d_ADDRESS = '0; bus.d_WRITEDATA = '0;
        bus.i_READ = 0; bus.i_ADDRESS = '0;
        for (int a = 0; a < 64; a++) begin
            phys[a]    = $urandom;
            ref_mem[a] = phys[a];
        end
        d_last_rd = '0;

        // Reset state
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_mem_read",   bus.mem_READ, 1'b0);
        check("rst_mem_write",  bus.mem_WRITE, 1'b0);
        check("rst_mem_addr",   bus.mem_ADDRESS, '0);
        check("rst_mem_wdata",  bus.mem_WRITEDATA, '0);
        check("rst_d_rdata",    bus.d_READDATA, '0);
        check("rst_i_rdata",    bus.i_READDATA, '0);
        check("rst_timeout",    bus.mem_TIMEOUT, 1'b0);
        check("rst_d_busywait", bus.d_BUSYWAIT, 1'b0);
        check("rst_i_busywait", bus.i_BUSYWAIT, 1'b0);
        RESET = 1'b0;

        // Data read, memory busy 5 cycles: latency 2 + 5
        phys[6'h2A] = 32'hDEADBEEF; ref_mem[6'h2A] = 32'hDEADBEEF;
        fixed_lat = 5;
        fork
            d_access(1'b0, 1'b0, 6'h2A, '0, cyc_d);
            begin
                @(negedge CLK);
                check("t1_mem_read", bus.mem_READ, 1'b1);
                check("t1_mem_addr", bus.mem_ADDRESS, 6'h2A);
                bus.d_ADDRESS = 6'h11;   // must not reach memory mid-grant
            end
        join
        check("t1_latency", cyc_d, 7);
        check("t1_d_rdata", bus.d_READDATA, 32'hDEADBEEF);
        check("t1_i_rdata", bus.i_READDATA, '0);

        // Data write-back: strobes and data forwarded, read data untouched
        repeat (2) @(negedge CLK);
        fixed_lat = 2;
        d_access(1'b1, 1'b0, 6'h05, 32'h01020304, cyc_d);
        check("t2_latency",   cyc_d, 4);
        check("t2_mem_write", snap_wr, 1'b1);
        check("t2_mem_read",  snap_rd, 1'b0);
        check("t2_mem_wdata", snap_wdata, 32'h01020304);
        check("t2_mem_addr",  snap_addr, 6'h05);
        check("t2_phys",      phys[6'h05], 32'h01020304);

        // Instruction read withdrawn on the 2nd grant cycle
        repeat (2) @(negedge CLK);
        phys[6'h33] = 32'hCAFEF00D; ref_mem[6'h33] = 32'hCAFEF00D;
        fixed_lat = 4;
        bus.i_READ = 1'b1; bus.i_ADDRESS = 6'h33;
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 2) bus.i_READ = 1'b0;
            if (k == 5) check("t3_read_held", bus.mem_READ, 1'b1);
            if (k == 6) begin
                check("t3_read_dropped", bus.mem_READ, 1'b0);
                check("t3_i_rdata",      bus.i_READDATA, 32'hCAFEF00D);
                check("t3_i_busywait",   bus.i_BUSYWAIT, 1'b0);
            end
        end
        fixed_lat = 1;
        d_access(1'b0, 1'b0, 6'h33, '0, cyc_d);
        check("t3_idle_after", cyc_d, 3);

        // Simultaneous requests after reset: D first, I after DONE_D + IDLE
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        d_last_rd = '0;
        grant_log.delete();
        fixed_lat = 2;
        fork
            d_access(1'b0, 1'b0, 6'h2A, '0, cyc_d);
            i_access(6'h33, cyc_i);
        join
        check("t4_d_latency", cyc_d, 4);
        check("t4_i_latency", cyc_i, 9);
        check("t4_log_size", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t4_first",  grant_log[0], 0);
            check("t4_second", grant_log[1], 1);
        end

        // Both held continuously for six transactions: strict alternation
        grant_log.delete();
        fixed_lat = -1;
        fork
            for (int n = 0; n < 3; n++) d_access(1'b0, 1'b0, AW'($urandom), '0, cyc_a);
            for (int n = 0; n < 3; n++) i_access(AW'($urandom), cyc_b);
        join
        check("t5_log_size", grant_log.size(), 6);
        for (int n = 0; n < grant_log.size(); n++) begin
            check($sformatf("t5_order_%0d", n), grant_log[n], n % 2);
        end

        // Randomized traffic from both caches with random gaps and latencies
        fork
            for (int n = 0; n < 25; n++) begin
                bit wr;
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                wr = 1'($urandom_range(0, 1));
                d_access(wr, wr & 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, cyc_a);
            end
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                i_access(AW'($urandom_range(0, 7)), cyc_b);
            end
        join

        // Watchdog: memory stuck busy; flag on the 255th busy grant cycle's edge
        repeat (2) @(negedge CLK);
        stuck = 1'b1;
        bus.i_READ = 1'b1; bus.i_ADDRESS = 6'h07;
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLK);
            if (k == 255) check("t7_timeout_early", bus.mem_TIMEOUT, 1'b0);
            if (k == 256) check("t7_timeout_set",   bus.mem_TIMEOUT, 1'b1);
            if (k == 300) begin
                check("t7_timeout_sticky", bus.mem_TIMEOUT, 1'b1);
                check("t7_still_waiting",  bus.mem_READ, 1'b1);
                check("t7_i_stalled",      bus.i_BUSYWAIT, 1'b1);
            end
        end
        RESET = 1'b1;
        @(negedge CLK);
        check("t7_rst_read",    bus.mem_READ, 1'b0);
        check("t7_rst_write",   bus.mem_WRITE, 1'b0);
        check("t7_rst_addr",    bus.mem_ADDRESS, '0);
        check("t7_rst_timeout", bus.mem_TIMEOUT, 1'b0);
        check("t7_rst_d_rdata", bus.d_READDATA, '0);
        check("t7_rst_i_rdata", bus.i_READDATA, '0);
        bus.i_READ = 1'b0;
        stuck      = 1'b0;
        RESET      = 1'b0;
        d_last_rd  = '0;
        fixed_lat  = 1;
        d_access(1'b0, 1'b0, 6'h2A, '0, cyc_d);
        check("t7_recover_latency", cyc_d, 3);

        check("bus_frozen_and_legal", bus_violations, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-wide main memory between the instruction cache (read-only) and the data cache (read/write).
- Sits between both cache controllers' memory-side ports and the one data-memory instance.
- Serialises block transfers, forwards the granted cache's strobes, address and data, and returns read data and busywait per requester.
- Round-robin arbitration, plus a watchdog on stuck memory busywait.

Parameters:
- ADDR_W, 6, block address width (tag+index).
- DATA_W, 32, block width in bits.
- TIMEOUT, 255, max GRANT cycles with mem_BUSYWAIT high before the error flag sets.

Ports:
- CLK  in  1  clock, all state on posedge.
- RESET  in  1  synchronous, active-high reset.
- d_READ  in  1  data cache block read request.
- d_WRITE  in  1  data cache block write-back request.
- d_ADDRESS  in  ADDR_W  data cache block address.
- d_WRITEDATA  in  DATA_W  data cache write-back block.
- d_READDATA  out  DATA_W  block returned to data cache.
- d_BUSYWAIT  out  1  data cache stall.
- i_READ  in  1  instruction cache block read request.
- i_ADDRESS  in  ADDR_W  instruction cache block address.
- i_READDATA  out  DATA_W  block returned to instruction cache.
- i_BUSYWAIT  out  1  instruction cache stall.
- mem_READ  out  1  memory read strobe.
- mem_WRITE  out  1  memory write strobe.
- mem_ADDRESS  out  ADDR_W  memory block address.
- mem_WRITEDATA  out  DATA_W  memory write block.
- mem_READDATA  in  DATA_W  memory read block.
- mem_BUSYWAIT  in  1  memory busy; low = access complete.
- mem_TIMEOUT  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, GRANT_D, GRANT_I, DONE_D, DONE_I. last_grant register holds D or I.
- Request decode:
  - d_req = d_READ|d_WRITE.
  - If d_READ and d_WRITE are both high, it is treated as a write.
  - i_req = i_READ.
- Reset (sync, one edge): state=IDLE, last_grant=I (so D wins the first tie).
  - mem_READ=0, mem_WRITE=0, mem_ADDRESS=0, mem_WRITEDATA=0.
  - d_READDATA=0, i_READDATA=0, mem_TIMEOUT=0, watchdog count=0.
  - Reset overrides a grant in flight; the memory transaction is abandoned.
- Busywait (combinational):
  - d_BUSYWAIT = d_req & ~(state==DONE_D).
  - i_BUSYWAIT = i_req & ~(state==DONE_I).
  - The requester not granted stays stalled for the whole transaction.
- IDLE:
  - Only d_req → GRANT_D. Only i_req → GRANT_I.
  - Both → the one not equal to last_grant.
  - Neither → stay IDLE.
- GRANT entry edge (registered outputs):
  - GRANT_D: mem_ADDRESS=d_ADDRESS; mem_READ=d_READ&~d_WRITE; mem_WRITE=d_WRITE; mem_WRITEDATA=d_WRITEDATA for a write, else 0.
  - GRANT_I: mem_ADDRESS=i_ADDRESS; mem_READ=1; mem_WRITE=0; mem_WRITEDATA=0.
  - Address, data and strobes are frozen for the whole grant; requester changes are ignored.
- GRANT_x completion:
  - mem_BUSYWAIT is ignored on the first GRANT cycle (memory response settling).
  - From the second cycle, mem_BUSYWAIT==0 at a posedge → DONE_x.
  - On that same edge, x_READDATA<=mem_READDATA (reads only; writes leave it unchanged), mem_READ/mem_WRITE<=0, last_grant<=x.
- DONE_x: exactly one cycle, x_BUSYWAIT low; next state IDLE.
  - If the requester still holds its request in IDLE, it is a new request and is arbitrated normally.
  - Minimum turnaround between grants: 1 IDLE cycle.
- Request withdrawn during GRANT: the transaction runs to completion (memory cannot abort); data is still latched; the DONE pulse is harmless.
- Latency from request high in IDLE to BUSYWAIT low = 2 + N cycles, where N = GRANT cycles after the first before mem_BUSYWAIT is sampled low.
- Watchdog:
  - Counter clears on GRANT entry and increments each GRANT cycle with mem_BUSYWAIT=1.
  - On reaching TIMEOUT, mem_TIMEOUT<=1 (sticky until RESET); the FSM keeps waiting.
  - The counter saturates and does not wrap.
- Starvation bound: with both requesting continuously, grants alternate D,I,D,I.

Test Plan:
- Reset, then d_READ=1, d_ADDRESS=6'h2A; memory model BUSYWAIT high 5 cycles, READDATA=32'hDEADBEEF → mem_READ=1, mem_ADDRESS=6'h2A from cycle 1; d_BUSYWAIT low one cycle in DONE_D with d_READDATA=32'hDEADBEEF; i_READDATA stays 0.
- d_WRITE=1, d_ADDRESS=6'h05, d_WRITEDATA=32'h01020304 → mem_WRITE=1, mem_WRITEDATA=32'h01020304; d_READDATA unchanged after completion.
- d_READ and i_READ raised on the same cycle after reset → D granted first; I granted after the DONE_D+IDLE cycles; i_BUSYWAIT high throughout D's transaction.
- Both requesters held continuously for 6 transactions → grant order D,I,D,I,D,I.
- i_READ dropped on the 2nd GRANT_I cycle → mem_READ stays high until mem_BUSYWAIT low; i_READDATA latched; FSM returns to IDLE.
- mem_BUSYWAIT held high 300 cycles with TIMEOUT=255 → mem_TIMEOUT=1 at GRANT cycle 255; RESET mid-grant → state IDLE, strobes 0, mem_TIMEOUT=0 after one edge.
